// File: rtl/bcd_value_entry_if.sv
// Front-panel bundle: raw push-buttons in, edited BCD digits and converted sample out.
// The design takes the slave side; whoever drives the buttons takes the master side.
interface bcd_value_entry_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_next;
    logic       btn_sign;
    logic       btn_enter;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       thousands;
    logic [1:0] cursor;
    logic [8:0] value;
    logic       value_valid;
    logic       busy;
    logic       clamped;

    modport slave (
        input  btn_up, btn_down, btn_next, btn_sign, btn_enter,
        output ones, tens, hundreds, thousands, cursor,
        output value, value_valid, busy, clamped
    );

    modport master (
        output btn_up, btn_down, btn_next, btn_sign, btn_enter,
        input  ones, tens, hundreds, thousands, cursor,
        input  value, value_valid, busy, clamped
    );
endinterface

// File: rtl/bcd_value_entry.sv
// Debounced BCD digit/sign editor with a sequential BCD-to-signed-binary converter.
// Conversion result appears 5 cycles after the enter press; an enter press while busy is dropped.
module bcd_value_entry #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_MAG         = 255
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    bcd_value_entry_if.slave  bus
);
    localparam int NB = 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]    MAX_ACC  = 10'(MAX_MAG);
    localparam logic [7:0]    MAX_MAG8 = 8'(MAX_MAG);

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_NEXT  = 2;
    localparam int B_SIGN  = 3;
    localparam int B_ENTER = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] stable_q, stable_d;
    logic [NB-1:0] press;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    logic [2:0][3:0] dig_q, dig_d;
    logic            sign_q, sign_d;
    logic [1:0]      cursor_q, cursor_d;
    logic            edit_up, edit_dn;

    logic [1:0]      state_q, state_d;
    logic [9:0]      acc_q, acc_d;
    logic [1:0]      step_q, step_d;
    logic [2:0][3:0] snap_q, snap_d;
    logic            snap_sign_q, snap_sign_d;
    logic [8:0]      value_q, value_d;
    logic            clamped_q, clamped_d;
    logic            valid_q, valid_d;
    logic [3:0]      cur_digit;
    logic            over;
    logic [7:0]      mag;

    assign raw = {bus.btn_enter, bus.btn_sign, bus.btn_next, bus.btn_down, bus.btn_up};

    // A level must differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign edit_up = press[B_UP] & ~press[B_DOWN];
    assign edit_dn = press[B_DOWN] & ~press[B_UP];

    // Edits use the cursor position from before any coincident next press.
    always_comb begin
        dig_d    = dig_q;
        sign_d   = sign_q ^ press[B_SIGN] ^ ((cursor_q == 2'd3) & (edit_up | edit_dn));
        cursor_d = cursor_q + {1'b0, press[B_NEXT]};
        for (int i = 0; i < 3; i++) begin
            if (cursor_q == 2'(i)) begin
                if (edit_up) begin
                    dig_d[i] = (dig_q[i] == 4'd9) ? 4'd0 : dig_q[i] + 4'd1;
                end else if (edit_dn) begin
                    dig_d[i] = (dig_q[i] == 4'd0) ? 4'd9 : dig_q[i] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        snap_d      = snap_q;
        snap_sign_d = snap_sign_q;
        value_d     = value_q;
        clamped_d   = clamped_q;
        valid_d     = 1'b0;
        over        = acc_q > MAX_ACC;
        mag         = over ? MAX_MAG8 : acc_q[7:0];
        case (step_q)
            2'd0:    cur_digit = snap_q[2];
            2'd1:    cur_digit = snap_q[1];
            default: cur_digit = snap_q[0];
        endcase
        case (state_q)
            ST_IDLE: begin
                if (press[B_ENTER]) begin
                    snap_d      = dig_q;
                    snap_sign_d = sign_q;
                    acc_d       = '0;
                    step_d      = '0;
                    state_d     = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d  = acc_q * 10'd10 + {6'd0, cur_digit};
                step_d = step_q + 2'd1;
                if (step_q == 2'd2) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                clamped_d = over;
                // Negating a zero magnitude wraps back to zero, so -0 never appears.
                value_d   = snap_sign_q ? (~{1'b0, mag} + 9'd1) : {1'b0, mag};
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            dig_q       <= '0;
            sign_q      <= 1'b0;
            cursor_q    <= 2'd0;
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            step_q      <= '0;
            snap_q      <= '0;
            snap_sign_q <= 1'b0;
            value_q     <= '0;
            clamped_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dig_q       <= dig_d;
            sign_q      <= sign_d;
            cursor_q    <= cursor_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            snap_q      <= snap_d;
            snap_sign_q <= snap_sign_d;
            value_q     <= value_d;
            clamped_q   <= clamped_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.ones        = dig_q[0];
    assign bus.tens        = dig_q[1];
    assign bus.hundreds    = dig_q[2];
    assign bus.thousands   = sign_q;
    assign bus.cursor      = cursor_q;
    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.clamped     = clamped_q;
endmodule

// File: tb/tb_bcd_value_entry.sv
// Bench for bcd_value_entry: editing vector table, conversion scoreboard, bounce/reset/busy corner cases.
module tb_bcd_value_entry;
    localparam logic [4:0] U = 5'b00001;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] N = 5'b00100;
    localparam logic [4:0] S = 5'b01000;
    localparam logic [4:0] E = 5'b10000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_value_entry_if bif ();
    bcd_value_entry_if bif_f ();

    bcd_value_entry #(.DEBOUNCE_CYCLES(4), .MAX_MAG(255)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bif.slave)
    );

    // Second instance with a one-cycle debounce so enter can be re-pressed inside the busy window.
    bcd_value_entry #(.DEBOUNCE_CYCLES(1), .MAX_MAG(255)) u_fast (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bif_f.slave)
    );

    typedef struct {
        logic [8:0] value;
        logic       clamped;
    } exp_t;

    typedef struct {
        logic [4:0] btns;
        int o;
        int t;
        int h;
        int s;
        int c;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   run = 0;
    int   vld_seen = 0;
    int   fvld_seen = 0;
    int   m_dig[3];
    int   m_sign;
    int   m_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] m);
        bif.btn_up    = m[0];
        bif.btn_down  = m[1];
        bif.btn_next  = m[2];
        bif.btn_sign  = m[3];
        bif.btn_enter = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        drive(m);
        cyc(8);
        drive(5'b0);
        cyc(8);
    endtask

    task automatic check_display(input string tag);
        check({tag, "_ones"},      bif.ones,      m_dig[0]);
        check({tag, "_tens"},      bif.tens,      m_dig[1]);
        check({tag, "_hundreds"},  bif.hundreds,  m_dig[2]);
        check({tag, "_thousands"}, bif.thousands, m_sign);
        check({tag, "_cursor"},    bif.cursor,    m_cur);
    endtask

    task automatic go_cursor(input int c);
        while (m_cur != c) begin
            press(N);
            m_cur = (m_cur + 1) % 4;
        end
    endtask

    task automatic set_digit(input int i, input int v);
        int ups;
        go_cursor(i);
        ups = (v - m_dig[i] + 10) % 10;
        while (m_dig[i] != v) begin
            if (ups <= 5) begin
                press(U);
                m_dig[i] = (m_dig[i] + 1) % 10;
            end else begin
                press(D);
                m_dig[i] = (m_dig[i] + 9) % 10;
            end
        end
    endtask

    task automatic set_sign(input int s);
        if (m_sign != s) begin
            press(S);
            m_sign = s;
        end
    endtask

    function automatic exp_t model();
        exp_t r;
        int   n;
        int   mg;
        n         = m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
        r.clamped = (n > 255);
        mg        = r.clamped ? 255 : n;
        r.value   = (m_sign != 0) ? 9'(-mg) : 9'(mg);
        return r;
    endfunction

    task automatic do_enter(input string tag);
        exp_t e;
        e = model();
        sb.push_back(e);
        press(E);
        cyc(4);
        check({tag, "_sb_drained"}, sb.size(), 0);
        check({tag, "_value_held"}, bif.value, e.value);
        check({tag, "_busy_idle"},  bif.busy,  0);
    endtask

    // Scoreboard consumer and busy-window monitor.
    always @(negedge clk) begin
        if (bif.value_valid === 1'b1) begin
            exp_t e;
            vld_seen++;
            check("busy_len_before_valid", run, 4);
            check("busy_low_at_valid", bif.busy, 0);
            check("sb_depth_at_valid", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("value", bif.value, e.value);
                check("clamped", bif.clamped, e.clamped);
            end
        end
        run = (bif.busy === 1'b1) ? run + 1 : 0;
        if (bif_f.value_valid === 1'b1) fvld_seen++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        drive(5'b0);
        bif_f.btn_up = 0; bif_f.btn_down = 0; bif_f.btn_next = 0;
        bif_f.btn_sign = 0; bif_f.btn_enter = 0;
        reset = 1'b1;

        vt[0]  = '{D,     9, 0, 0, 0, 0};
        vt[1]  = '{U,     0, 0, 0, 0, 0};
        vt[2]  = '{U | D, 0, 0, 0, 0, 0};
        vt[3]  = '{D,     9, 0, 0, 0, 0};
        vt[4]  = '{D,     8, 0, 0, 0, 0};
        vt[5]  = '{D,     7, 0, 0, 0, 0};
        vt[6]  = '{N,     7, 0, 0, 0, 1};
        vt[7]  = '{U,     7, 1, 0, 0, 1};
        vt[8]  = '{U | N, 7, 2, 0, 0, 2};
        vt[9]  = '{U,     7, 2, 1, 0, 2};
        vt[10] = '{N,     7, 2, 1, 0, 3};
        vt[11] = '{U,     7, 2, 1, 1, 3};
        vt[12] = '{D,     7, 2, 1, 0, 3};
        vt[13] = '{S | U, 7, 2, 1, 0, 3};
        vt[14] = '{S,     7, 2, 1, 1, 3};
        vt[15] = '{N,     7, 2, 1, 1, 0};

        cyc(3);
        reset = 1'b0;
        cyc(1);
        m_dig = '{0, 0, 0}; m_sign = 0; m_cur = 0;
        check_display("rst");
        check("rst_value", bif.value, 0);
        check("rst_valid", bif.value_valid, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_clamped", bif.clamped, 0);

        do_enter("zero");

        for (int i = 0; i < 16; i++) begin
            press(vt[i].btns);
            check($sformatf("v%0d_ones", i),   bif.ones,      vt[i].o);
            check($sformatf("v%0d_tens", i),   bif.tens,      vt[i].t);
            check($sformatf("v%0d_hund", i),   bif.hundreds,  vt[i].h);
            check($sformatf("v%0d_sign", i),   bif.thousands, vt[i].s);
            check($sformatf("v%0d_cursor", i), bif.cursor,    vt[i].c);
        end
        m_dig = '{7, 2, 1}; m_sign = 1; m_cur = 0;
        do_enter("neg127");
        check("neg127_literal", bif.value, 9'h181);

        set_digit(0, 9); set_digit(1, 9); set_digit(2, 9); set_sign(0);
        check_display("d999");
        do_enter("pos999");
        check("pos999_literal", bif.value, 9'h0FF);

        set_digit(0, 0); set_digit(1, 0); set_digit(2, 3); set_sign(1);
        do_enter("neg300");
        check("neg300_literal", bif.value, 9'h101);

        set_digit(0, 2); set_digit(1, 4); set_digit(2, 0); set_sign(0);
        check_display("d042");
        do_enter("pos042");
        check("pos042_literal", bif.value, 9'h02A);

        // Bounce rejection, then a long press with a one-cycle glitch.
        go_cursor(0);
        bif.btn_up = 1'b1; cyc(2); bif.btn_up = 1'b0; cyc(10);
        check_display("bounce_short");
        bif.btn_up = 1'b1; cyc(5); bif.btn_up = 1'b0; cyc(1);
        bif.btn_up = 1'b1; cyc(4); bif.btn_up = 1'b0; cyc(10);
        m_dig[0] = 3;
        check_display("bounce_glitch");

        set_digit(0, 0); set_digit(1, 0); set_sign(1);
        do_enter("negzero");
        check("negzero_clamped", bif.clamped, 0);

        // Reset in the middle of a conversion.
        v0 = vld_seen;
        bif.btn_enter = 1'b1;
        for (int k = 0; k < 30 && bif.busy !== 1'b1; k++) cyc(1);
        check("midrst_busy_rise", bif.busy, 1);
        bif.btn_enter = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("midrst_busy_drop", bif.busy, 0);
        reset = 1'b0;
        cyc(20);
        m_dig = '{0, 0, 0}; m_sign = 0; m_cur = 0;
        check("midrst_no_valid", vld_seen - v0, 0);
        check("midrst_value", bif.value, 0);
        check_display("midrst");

        // Enter re-pressed during busy on the fast instance: one result only.
        bif_f.btn_up = 1'b1; cyc(1); bif_f.btn_up = 1'b0; cyc(5);
        check("fast_ones", bif_f.ones, 1);
        v0 = fvld_seen;
        bif_f.btn_enter = 1'b1; cyc(1); bif_f.btn_enter = 1'b0; cyc(1);
        bif_f.btn_enter = 1'b1; cyc(1); bif_f.btn_enter = 1'b0;
        cyc(15);
        check("fast_single_valid", fvld_seen - v0, 1);
        check("fast_value", bif_f.value, 9'h001);
        check("fast_busy", bif_f.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
